// File: rtl/name_pkg.sv
// Shared constants for the "RICKY" name generator/checker pair.
// No logic of its own: character codes and one-hot position encoding.
// Both ends import this package so they agree on the ring-counter image.
package name_pkg;

  // ASCII codes of the five name characters, in order
  localparam logic [7:0] CH_R = 8'h52;
  localparam logic [7:0] CH_I = 8'h49;
  localparam logic [7:0] CH_C = 8'h43;
  localparam logic [7:0] CH_K = 8'h4B;
  localparam logic [7:0] CH_Y = 8'h59;

  // One-hot position encoding, identical to the generator's ring counter
  localparam logic [4:0] EXP_R = 5'b00001;
  localparam logic [4:0] EXP_I = 5'b00010;
  localparam logic [4:0] EXP_C = 5'b00100;
  localparam logic [4:0] EXP_K = 5'b01000;
  localparam logic [4:0] EXP_Y = 5'b10000;

  // Advance the ring by one position, Y wrapping back to R
  function automatic logic [4:0] pos_rotl(input logic [4:0] p);
    return {p[3:0], p[4]};
  endfunction

endpackage

// File: rtl/name_char_decode.sv
// Maps an ASCII character to its one-hot position in "RICKY"; zero if absent.
// Purely combinational, zero latency.
// No flow control: evaluates every cycle regardless of valid.
module name_char_decode
  import name_pkg::*;
(
  input  logic [7:0] char_in,
  output logic [4:0] hit
);

  // Exact 8-bit compare; lower case and any other code give no hit
  always_comb begin
    hit = 5'b00000;
    case (char_in)
      CH_R:    hit = EXP_R;
      CH_I:    hit = EXP_I;
      CH_C:    hit = EXP_C;
      CH_K:    hit = EXP_K;
      CH_Y:    hit = EXP_Y;
      default: hit = 5'b00000;
    endcase
  end

endmodule

// File: rtl/name_checker.sv
// Tracks progress through "RICKY", pulses match/err, counts complete names.
// All outputs registered: response to a beat is visible one cycle later.
// Never backpressures; accepts one valid beat every cycle.
module name_checker
  import name_pkg::*;
#(
  parameter int COUNT_W = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               char_valid,
  input  logic [7:0]         char_in,
  output logic [4:0]         pos,
  output logic               match,
  output logic               err,
  output logic [COUNT_W-1:0] match_count
);

  localparam logic [COUNT_W-1:0] CNT_MAX = {COUNT_W{1'b1}};

  logic [4:0]         pos_q, pos_d;
  logic               match_q, match_d;
  logic               err_q, err_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]         hit;
  logic               in_seq;
  logic               restart;

  name_char_decode u_decode (
    .char_in (char_in),
    .hit     (hit)
  );

  // An 'R' out of place is still the start of a new name, so it lands on EXP_I
  assign in_seq  = |(hit & pos_q);
  assign restart = hit[0];

  // Next-state: advance on the expected char, otherwise flag and resync
  always_comb begin
    pos_d   = pos_q;
    match_d = 1'b0;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    if (char_valid) begin
      if (in_seq) begin
        pos_d = pos_rotl(pos_q);
        if (pos_q[4]) begin
          match_d = 1'b1;
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end else begin
        err_d = 1'b1;
        pos_d = restart ? EXP_I : EXP_R;
      end
    end
  end

  // State registers; reset wins over a same-cycle beat and drops it
  always_ff @(posedge CLK) begin
    if (RST) begin
      pos_q   <= EXP_R;
      match_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pos_q   <= pos_d;
      match_q <= match_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pos         = pos_q;
  assign match       = match_q;
  assign err         = err_q;
  assign match_count = cnt_q;

endmodule
